// File: rtl/instr_prefetch_queue_pkg.sv
// Shared defaults and types for the instruction prefetch front-end.
package instr_prefetch_queue_pkg;

  localparam int unsigned WIDTH_DEF    = 32;
  localparam int unsigned ADDRSIZE_DEF = 12;
  localparam int unsigned DEPTH_DEF    = 4;

  // What happens to a memory return in a given cycle.
  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_DROP = 2'd1,
    RET_PUSH = 2'd2
  } ret_action_e;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_ins_fifo.sv
// Synchronous show-ahead FIFO holding {addr, data} entries, with flush.
module ins_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DW    = 44,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  output logic                   head_valid_o,
  output logic [DW-1:0]          head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [DW-1:0] mem_q [DEPTH];
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  cnt_t          count_q, count_d;
  logic          do_push, do_pop;

  // Pointer/count next state; flush wins over push and pop.
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != cnt_t'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push & ~flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front-end: credit-limited sequential fetch, in-order
// return queue, and redirect flush with discard of stale in-flight returns.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDRSIZE-1:0]    imem_addr,
  input  logic                   imem_valid,
  input  logic [0:WIDTH-1]       imem_data,
  output logic                   ins_valid,
  output logic [0:WIDTH-1]       ins_data,
  output logic [ADDRSIZE-1:0]    ins_addr,
  input  logic                   ins_ready,
  input  logic                   redirect,
  input  logic [ADDRSIZE-1:0]    redirect_addr,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned DW = ADDRSIZE + WIDTH;

  typedef logic [CW-1:0]       cnt_t;
  typedef logic [SW-1:0]       sum_t;
  typedef logic [ADDRSIZE-1:0] addr_t;

  addr_t       fetch_pc_q, fetch_pc_d;
  addr_t       resp_pc_q,  resp_pc_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_q,     drop_d;
  logic        err_q,      err_d;
  logic        ret, spurious, push, pop;
  ret_action_e action;
  cnt_t        occ;
  logic [DW-1:0] head;

  assign ret      = imem_valid & (inflight_q != '0);
  assign spurious = imem_valid & (inflight_q == '0);

  // Credit rule: queued plus outstanding never exceeds the queue depth.
  assign imem_req  = rst & ~redirect & ((sum_t'(occ) + sum_t'(inflight_q)) < sum_t'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // Classify the current return as dropped (stale) or kept.
  always_comb begin
    action = RET_NONE;
    if (ret) action = (drop_q != '0) ? RET_DROP : RET_PUSH;
  end

  assign push = (action == RET_PUSH) & ~redirect;
  assign pop  = ins_valid & ins_ready;

  // Counter and address next state; redirect overrides the normal update.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    err_d      = err_q | spurious;
    if (redirect) begin
      // No request issues under redirect, so only a return can retire.
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      inflight_d = inflight_q - cnt_t'(ret);
      drop_d     = inflight_q - cnt_t'(ret);
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + addr_t'(1);
      inflight_d = inflight_q + cnt_t'(imem_req) - cnt_t'(ret);
      case (action)
        RET_DROP: drop_d    = drop_q - cnt_t'(1);
        RET_PUSH: resp_pc_d = resp_pc_q + addr_t'(1);
        default:  ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  ins_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_ni       (rst),
    .flush_i      (redirect),
    .push_i       (push),
    .push_data_i  ({resp_pc_q, imem_data}),
    .pop_i        (pop),
    .head_valid_o (ins_valid),
    .head_data_o  (head),
    .count_o      (occ)
  );

  assign ins_addr  = head[DW-1 -: ADDRSIZE];
  assign ins_data  = head[WIDTH-1:0];
  assign occupancy = occ;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a 2-cycle-latency ROM model.
module tb_instr_prefetch_queue;

  localparam int unsigned W = 32;
  localparam int unsigned A = 12;
  localparam int unsigned D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           imem_req;
  logic [A-1:0]   imem_addr;
  logic           imem_valid;
  logic [0:W-1]   imem_data;
  logic           ins_valid;
  logic [0:W-1]   ins_data;
  logic [A-1:0]   ins_addr;
  logic           ins_ready;
  logic           redirect;
  logic [A-1:0]   redirect_addr;
  logic [2:0]     occupancy;
  logic           err;

  int checks    = 0;
  int failures  = 0;
  int reqs_seen = 0;

  // Memory pipeline: stage 1 holds the request accepted at the last edge,
  // stage 2 the one before; stage 2 drives the return.
  logic         p1v, p2v;
  logic [A-1:0] p1a, p2a;

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .WIDTH    (W),
    .ADDRSIZE (A),
    .DEPTH    (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .ins_valid     (ins_valid),
    .ins_data      (ins_data),
    .ins_addr      (ins_addr),
    .ins_ready     (ins_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .occupancy     (occupancy),
    .err           (err)
  );

  function automatic logic [W-1:0] rom(input logic [A-1:0] a);
    logic [31:0] v;
    v = {20'b0, a} * 32'h11;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; samples the request, crosses one edge, advances memory.
  task automatic tick();
    logic         req_s;
    logic [A-1:0] addr_s;
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    if (req_s) reqs_seen++;
    @(posedge clk);
    #1;
    p2v = p1v;
    p2a = p1a;
    p1v = req_s;
    p1a = addr_s;
    imem_valid = p2v;
    imem_data  = rom(p2a);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    p1v = 1'b0; p2v = 1'b0; p1a = '0; p2a = '0;
    imem_valid = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic head(input string tag, input logic [A-1:0] a);
    chk({tag, "_valid"}, 64'(ins_valid), 64'd1);
    chk({tag, "_addr"},  64'(ins_addr),  64'(a));
    chk({tag, "_data"},  64'(ins_data),  64'(rom(a)));
  endtask

  task automatic redirect_to(input logic [A-1:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    #1;
    chk("redir_req_blocked", 64'(imem_req), 64'd0);
    tick();
    chk("redir_flush_valid", 64'(ins_valid), 64'd0);
    chk("redir_flush_occ",   64'(occupancy), 64'd0);
    redirect = 1'b0;
  endtask

  task automatic expect_first(input logic [A-1:0] a);
    #1;
    chk("refetch_req",  64'(imem_req),  64'd1);
    chk("refetch_addr", 64'(imem_addr), 64'(a));
    tick();
    chk("no_stale_1", 64'(ins_valid), 64'd0);
    tick();
    chk("no_stale_2", 64'(ins_valid), 64'd0);
    tick();
    head("first_after_redir", a);
  endtask

  initial begin
    rst = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    imem_valid = 1'b0; imem_data = '0;
    p1v = 1'b0; p2v = 1'b0; p1a = '0; p2a = '0;

    // Reset state
    #2;
    chk("rst_req",   64'(imem_req),  64'd0);
    chk("rst_valid", 64'(ins_valid), 64'd0);
    chk("rst_data",  64'(ins_data),  64'd0);
    chk("rst_addr",  64'(ins_addr),  64'd0);
    chk("rst_occ",   64'(occupancy), 64'd0);
    chk("rst_err",   64'(err),       64'd0);

    // 1. Streaming with the core always ready
    @(posedge clk);
    #1;
    rst = 1'b1;
    ins_ready = 1'b1;
    #1;
    chk("first_req",  64'(imem_req),  64'd1);
    chk("first_addr", 64'(imem_addr), 64'd0);
    tick();
    tick();
    chk("latency_not_yet", 64'(ins_valid), 64'd0);
    tick(); head("stream0", 12'h000);
    tick(); head("stream1", 12'h001);
    tick(); head("stream2", 12'h002);
    chk("stream_occ", 64'(occupancy), 64'd1);

    // 2. Core stalled from reset: credit limit caps requests at the depth
    ins_ready = 1'b0;
    do_reset();
    reqs_seen = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("stall_reqs", 64'(reqs_seen), 64'd4);
    chk("stall_occ",  64'(occupancy), 64'd4);
    chk("stall_req",  64'(imem_req),  64'd0);
    ins_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head("drain", 12'(i));
      if (i == 1) begin
        chk("resume_req",  64'(imem_req),  64'd1);
        chk("resume_addr", 64'(imem_addr), 64'd4);
      end
      tick();
    end
    head("after_drain", 12'h004);

    // 3. Redirect with two requests in flight
    redirect_to(12'h100);
    expect_first(12'h100);
    tick(); head("redir_next", 12'h101);

    // 4. Address wrap after redirect near the top
    redirect_to(12'hFFE);
    expect_first(12'hFFE);
    tick(); head("wrap_fff", 12'hFFF);
    tick(); head("wrap_000", 12'h000);

    // 5. Back-to-back redirects, each coinciding with a return and a pop
    redirect_to(12'h200);
    redirect_to(12'h300);
    expect_first(12'h300);
    tick(); head("b2b_next", 12'h301);

    // 6. Asynchronous reset mid-stream, then a spurious return
    tick();
    rst = 1'b0;
    #2;
    chk("arst_valid", 64'(ins_valid), 64'd0);
    chk("arst_req",   64'(imem_req),  64'd0);
    chk("arst_occ",   64'(occupancy), 64'd0);
    chk("arst_err",   64'(err),       64'd0);
    p1v = 1'b0; p2v = 1'b0;
    imem_valid = 1'b1;
    imem_data  = 32'hDEAD_BEEF;
    rst = 1'b1;
    tick();
    chk("spurious_err",    64'(err),       64'd1);
    chk("spurious_nopush", 64'(ins_valid), 64'd0);
    tick();
    tick();
    head("post_err_stream", 12'h000);
    tick(); tick(); tick();
    chk("err_sticky", 64'(err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
